// File: rtl/conv_pkg.sv
// Shared conversion package: FSM state encoding, default word width and
// the sign-bit index macro used by both conversion directions.
`ifndef CONV_SIGN_IDX
`define CONV_SIGN_IDX(w) ((w) - 1)
`endif

package conv_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

endpackage

// File: rtl/twos2signed_serial_if.sv
// Valid/ready word interface for the bit-serial two's-complement to
// sign-magnitude converter: input word channel plus result channel.
interface twos2signed_serial_if #(
  parameter int WIDTH = conv_pkg::DEFAULT_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] t_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s_out;
  logic             ovf;

  modport master (
    output in_valid, t_in, out_ready,
    input  in_ready, out_valid, s_out, ovf
  );

  modport slave (
    input  in_valid, t_in, out_ready,
    output in_ready, out_valid, s_out, ovf
  );

endinterface

// File: rtl/serial_neg_cell.sv
// One-bit serial negate cell: copies bits up to and including the first 1,
// then inverts every later bit when neg is set.
module serial_neg_cell (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  input  logic neg,
  input  logic b,
  output logic o_bit
);

  logic r_seen_one;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen_one <= 1'b0;
    end else if (clr) begin
      r_seen_one <= 1'b0;
    end else if (en && neg) begin
      r_seen_one <= r_seen_one | b;
    end
  end

  assign o_bit = neg ? (r_seen_one ^ b) : b;

endmodule

// File: rtl/twos2signed_serial.sv
// Bit-serial two's-complement to sign-magnitude converter; magnitude is
// derived LSB-first, one bit per clock, and -2^(WIDTH-1) saturates.
module twos2signed_serial
  import conv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  twos2signed_serial_if.slave  bus
);

  localparam int CW   = $clog2(WIDTH);
  localparam int SIGN = `CONV_SIGN_IDX(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 2);

  conv_state_t      r_state;
  conv_state_t      w_state_next;
  logic [WIDTH-1:0] r_shift;
  logic             r_sign;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-2:0] r_mag;
  logic [WIDTH-1:0] r_s_out;
  logic             r_ovf;

  logic             w_accept;
  logic             w_step;
  logic             w_last;
  logic             w_bit;
  logic [WIDTH-2:0] w_mag_next;

  assign w_accept = (r_state == IDLE) && bus.in_valid;
  assign w_step   = (r_state == SHIFT);
  assign w_last   = w_step && (r_cnt == LAST_BIT);

  serial_neg_cell u_neg (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (w_accept),
    .en    (w_step),
    .neg   (r_sign),
    .b     (r_shift[0]),
    .o_bit (w_bit)
  );

  // Result bits enter the magnitude register from the MSB side.
  generate
    if (WIDTH > 2) begin : g_wide
      assign w_mag_next = {w_bit, r_mag[WIDTH-2:1]};
    end else begin : g_narrow
      assign w_mag_next = w_bit;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.in_valid)   w_state_next = SHIFT;
      SHIFT:   if (r_cnt == LAST_BIT) w_state_next = DONE;
      DONE:    if (bus.out_ready)  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_sign  <= 1'b0;
      r_cnt   <= '0;
      r_mag   <= '0;
      r_s_out <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift <= bus.t_in;
        r_sign  <= bus.t_in[SIGN];
        r_cnt   <= '0;
        r_mag   <= '0;
      end else if (w_step) begin
        r_shift <= r_shift >> 1;
        r_cnt   <= r_cnt + 1'b1;
        r_mag   <= w_mag_next;
      end
      // A negative word with an all-zero magnitude was 100..0: saturate.
      if (w_last) begin
        if (r_sign && (w_mag_next == '0)) begin
          r_s_out <= '1;
          r_ovf   <= 1'b1;
        end else begin
          r_s_out <= {r_sign, w_mag_next};
          r_ovf   <= 1'b0;
        end
      end
    end
  end

  assign bus.in_ready  = (r_state == IDLE);
  assign bus.out_valid = (r_state == DONE);
  assign bus.s_out     = r_s_out;
  assign bus.ovf       = r_ovf;

endmodule
